// File: rtl/wbutxarb_if.sv
// Byte-stream bundle between the two sources, the receive side and the transmitter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface wbutxarb_if;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       i_cmd_stb;
  logic [6:0] i_cmd_data;
  logic       o_cmd_busy;
  logic       i_con_stb;
  logic [6:0] i_con_data;
  logic       o_con_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       o_cmd_active;

  modport slave (
    input  i_rx_stb, i_rx_data, i_cmd_stb, i_cmd_data, i_con_stb, i_con_data, i_tx_busy,
    output o_cmd_busy, o_con_busy, o_tx_stb, o_tx_data, o_cmd_active
  );

  modport master (
    output i_rx_stb, i_rx_data, i_cmd_stb, i_cmd_data, i_con_stb, i_con_data, i_tx_busy,
    input  o_cmd_busy, o_con_busy, o_tx_stb, o_tx_data, o_cmd_active
  );
endinterface

// File: rtl/wbutxarb.sv
// Burst-limited round-robin arbiter tagging command (bit7=1) and console (bit7=0) bytes.
// Optional command-port idle timeout enabled by defining TXARB_CMD_TIMEOUT_EN.
module wbutxarb #(
  parameter int unsigned LGBURST                     = 4,
  parameter int unsigned LGIDLE                      = 24,
  parameter bit          CMD_PORT_OFF_UNTIL_ACCESSED = 1'b1
) (
  input logic        i_clk,
  input logic        i_reset,
  wbutxarb_if.slave  bus
);

  typedef enum logic {OwnCmd, OwnCon} owner_e;

  localparam logic [LGBURST:0] BurstCnt = {1'b1, {LGBURST{1'b0}}};
  localparam logic [LGBURST:0] CntOne   = {{LGBURST{1'b0}}, 1'b1};

  owner_e           owner_q, owner_d;
  logic [LGBURST:0] cnt_q, cnt_d;
  logic             tx_stb_q, tx_stb_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             cmd_active_q, cmd_active_d;

  logic cmd_valid, con_valid, load_ok, grant_cmd, grant_con, sel_cmd, rx_cmd;
  owner_e src;

  assign rx_cmd    = bus.i_rx_stb && bus.i_rx_data[7];
  assign cmd_valid = bus.i_cmd_stb && cmd_active_q;
  assign con_valid = bus.i_con_stb;
  assign load_ok   = !tx_stb_q || !bus.i_tx_busy;

  always_comb begin
    grant_cmd = 1'b0;
    grant_con = 1'b0;
    sel_cmd   = 1'b0;
    src       = owner_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    tx_stb_d  = tx_stb_q;
    tx_data_d = tx_data_q;

    if (cmd_valid && con_valid) begin
      // Owner keeps the link until its burst allowance is used up.
      sel_cmd   = (cnt_q < BurstCnt) ? (owner_q == OwnCmd) : (owner_q == OwnCon);
      grant_cmd = sel_cmd;
      grant_con = !sel_cmd;
    end else begin
      grant_cmd = cmd_valid;
      grant_con = con_valid;
    end

    if (load_ok) begin
      tx_stb_d = 1'b0;
      if (grant_cmd || grant_con) begin
        tx_stb_d  = 1'b1;
        tx_data_d = grant_cmd ? {1'b1, bus.i_cmd_data} : {1'b0, bus.i_con_data};
        src       = grant_cmd ? OwnCmd : OwnCon;
        if (src == owner_q) begin
          cnt_d = (cnt_q == BurstCnt) ? cnt_q : cnt_q + CntOne;
        end else begin
          owner_d = src;
          cnt_d   = CntOne;
        end
      end
    end
  end

  // An inactive command port swallows its bytes, so it never reports busy.
  assign bus.o_cmd_busy   = cmd_active_q && !(load_ok && grant_cmd);
  assign bus.o_con_busy   = !(load_ok && grant_con);
  assign bus.o_tx_stb     = tx_stb_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_cmd_active = cmd_active_q;

`ifdef TXARB_CMD_TIMEOUT_EN
  logic [LGIDLE-1:0] idle_q, idle_d;

  always_comb begin
    idle_d       = idle_q;
    cmd_active_d = cmd_active_q;
    if (rx_cmd) begin
      cmd_active_d = 1'b1;
      idle_d       = '0;
    end else if (cmd_active_q) begin
      if (&idle_q) begin
        cmd_active_d = 1'b0;
        idle_d       = '0;
      end else begin
        idle_d = idle_q + {{(LGIDLE-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  always_comb begin
    cmd_active_d = cmd_active_q || rx_cmd;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_q      <= OwnCmd;
      cnt_q        <= '0;
      tx_stb_q     <= 1'b0;
      tx_data_q    <= 8'h00;
      cmd_active_q <= !CMD_PORT_OFF_UNTIL_ACCESSED;
    end else begin
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      tx_stb_q     <= tx_stb_d;
      tx_data_q    <= tx_data_d;
      cmd_active_q <= cmd_active_d;
    end
  end

endmodule

// File: tb/tb_wbutxarb.sv
// Directed bench for wbutxarb with LGBURST=2 and LGIDLE=4.
module tb_wbutxarb;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wbutxarb_if ifc ();

  wbutxarb #(
    .LGBURST                    (2),
    .LGIDLE                     (4),
    .CMD_PORT_OFF_UNTIL_ACCESSED(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       acc_cmd, acc_con;
    logic [7:0] exp_byte;
    int         ec, en;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifc.i_rx_stb = 1'b0;  ifc.i_rx_data = 8'h00;
    ifc.i_cmd_stb = 1'b0; ifc.i_cmd_data = 7'h00;
    ifc.i_con_stb = 1'b0; ifc.i_con_data = 7'h00;
    ifc.i_tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_tx_stb", 8'(ifc.o_tx_stb), 8'h00);
    check("rst_tx_data", ifc.o_tx_data, 8'h00);
    check("rst_active", 8'(ifc.o_cmd_active), 8'h00);
    check("rst_owner", 8'(dut.owner_q), 8'h00);
    check("rst_cnt", 8'(dut.cnt_q), 8'h00);

    // Inactive command port discards bytes
    ifc.i_cmd_stb = 1'b1; ifc.i_cmd_data = 7'h25;
    #1;
    check("discard_busy", 8'(ifc.o_cmd_busy), 8'h00);
    tick();
    check("discard_nostb", 8'(ifc.o_tx_stb), 8'h00);
    // Activating rx with a command byte in the same cycle: byte still discarded
    ifc.i_cmd_data = 7'h11;
    ifc.i_rx_stb = 1'b1; ifc.i_rx_data = 8'h80;
    tick();
    ifc.i_rx_stb = 1'b0;
    ifc.i_cmd_stb = 1'b0;
    check("activate", 8'(ifc.o_cmd_active), 8'h01);
    check("same_cyc_discard", 8'(ifc.o_tx_stb), 8'h00);
    ifc.i_cmd_stb = 1'b1; ifc.i_cmd_data = 7'h25;
    #1;
    check("cmd_accept", 8'(ifc.o_cmd_busy), 8'h00);
    tick();
    ifc.i_cmd_stb = 1'b0;
    check("cmd_stb", 8'(ifc.o_tx_stb), 8'h01);
    check("cmd_data", ifc.o_tx_data, 8'hA5);
    tick();
    check("unload_stb", 8'(ifc.o_tx_stb), 8'h00);
    check("unload_hold", ifc.o_tx_data, 8'hA5);

    // Console only, back to back
    ifc.i_con_stb = 1'b1; ifc.i_con_data = 7'h41;
    tick();
    check("con1_stb", 8'(ifc.o_tx_stb), 8'h01);
    check("con1_data", ifc.o_tx_data, 8'h41);
    ifc.i_con_data = 7'h42;
    tick();
    ifc.i_con_stb = 1'b0;
    check("con2_stb", 8'(ifc.o_tx_stb), 8'h01);
    check("con2_data", ifc.o_tx_data, 8'h42);
    check("con_owner", 8'(dut.owner_q), 8'h01);
    check("con_cnt", 8'(dut.cnt_q), 8'h02);
    tick();
    check("con_idle", 8'(ifc.o_tx_stb), 8'h00);

    // Clean arbitration state, port active, rx activity held for the stream
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.i_rx_stb = 1'b1; ifc.i_rx_data = 8'h80;
    tick();
    check("stream_active", 8'(ifc.o_cmd_active), 8'h01);

    // Both streaming: bursts of four alternate, starting with command
    ec = 0;
    en = 0;
    ifc.i_cmd_stb = 1'b1;
    ifc.i_con_stb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifc.i_cmd_data = 7'(7'h10 + ec);
      ifc.i_con_data = 7'(7'h50 + en);
      if (((i / 4) % 2) == 0) exp_byte = {1'b1, 7'(7'h10 + ec)};
      else                    exp_byte = {1'b0, 7'(7'h50 + en)};
      #1;
      acc_cmd = !ifc.o_cmd_busy;
      acc_con = !ifc.o_con_busy;
      check("stream_one_grant", 8'(acc_cmd ^ acc_con), 8'h01);
      tick();
      check("stream_data", ifc.o_tx_data, exp_byte);
      if (acc_cmd) ec++;
      if (acc_con) en++;
    end
    check("stream_cmd_cnt", 8'(ec), 8'h08);
    check("stream_con_cnt", 8'(en), 8'h08);

    // Stalled transmitter: data stable and both sources held off
    ifc.i_cmd_data = 7'(7'h10 + ec);
    ifc.i_con_data = 7'(7'h50 + en);
    ifc.i_tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_cmd_busy", 8'(ifc.o_cmd_busy), 8'h01);
      check("stall_con_busy", 8'(ifc.o_con_busy), 8'h01);
      tick();
      check("stall_stb", 8'(ifc.o_tx_stb), 8'h01);
      check("stall_data", ifc.o_tx_data, 8'h57);
    end
    ifc.i_tx_busy = 1'b0;
    #1;
    check("release_cmd_go", 8'(ifc.o_cmd_busy), 8'h00);
    check("release_con_wait", 8'(ifc.o_con_busy), 8'h01);
    tick();
    check("release_stb", 8'(ifc.o_tx_stb), 8'h01);
    check("release_data", ifc.o_tx_data, 8'h98);

    // Reset while a byte is stuck in the holding register
    ifc.i_tx_busy = 1'b1;
    ifc.i_cmd_stb = 1'b0;
    ifc.i_con_stb = 1'b0;
    ifc.i_rx_stb = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.i_tx_busy = 1'b0;
    check("midrst_stb", 8'(ifc.o_tx_stb), 8'h00);
    check("midrst_owner", 8'(dut.owner_q), 8'h00);
    check("midrst_cnt", 8'(dut.cnt_q), 8'h00);
    check("midrst_active", 8'(ifc.o_cmd_active), 8'h00);

    // Activity flag lifetime without further rx traffic
    ifc.i_rx_stb = 1'b1; ifc.i_rx_data = 8'h80;
    tick();
    ifc.i_rx_stb = 1'b0;
`ifdef TXARB_CMD_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_still_active", 8'(ifc.o_cmd_active), 8'h01);
    end
    tick();
    check("to_expired", 8'(ifc.o_cmd_active), 8'h00);
    ifc.i_rx_stb = 1'b1;
    tick();
    ifc.i_rx_stb = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_expiry", 8'(ifc.o_cmd_active), 8'h01);
    ifc.i_rx_stb = 1'b1;
    tick();
    ifc.i_rx_stb = 1'b0;
    check("to_rx_wins", 8'(ifc.o_cmd_active), 8'h01);
    check("to_idle_clr", 8'(dut.idle_q), 8'h00);
`else
    for (int i = 0; i < 20; i++) tick();
    check("sticky_active", 8'(ifc.o_cmd_active), 8'h01);
`endif

    // A non-command rx byte must not activate the port
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.i_rx_stb = 1'b1; ifc.i_rx_data = 8'h7F;
    tick();
    ifc.i_rx_stb = 1'b0;
    check("con_rx_no_activate", 8'(ifc.o_cmd_active), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
